// File: rtl/sd_logger_pkg.sv
// sd_logger_pkg: shared FSM state type and default sizing for the SD logger sample path.
package sd_logger_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} feeder_state_t;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_BUSY_TMO = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with power-of-two depth and a combinational head word.
module sync_fifo
    import sd_logger_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign level = level_q;
    assign dout  = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/sample_fifo_feeder.sv
// sample_fifo_feeder: buffers samples in a FIFO and hands them one at a time to an SD SPI writer.
// Define SFF_DROP_CNT_EN to add a saturating 16-bit dropped-sample counter output drop_cnt.
module sample_fifo_feeder
    import sd_logger_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int BUSY_TMO = DEF_BUSY_TMO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   wr_busy,
    output logic                   wr_start,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
`ifdef SFF_DROP_CNT_EN
    output logic [15:0]            drop_cnt,
`endif
    output logic                   tmo_err
);
    localparam int CW = $clog2(BUSY_TMO);

    feeder_state_t     state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, head;
    logic              wr_start_q, wr_start_d;
    logic              overflow_q, overflow_d;
    logic              tmo_err_q, tmo_err_d;
    logic              push, pop, drop;
`ifdef SFF_DROP_CNT_EN
    logic [15:0]       drop_cnt_q, drop_cnt_d;
`endif

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (s_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_data_d = wr_data_q;
        tmo_err_d = tmo_err_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: if (!empty && !wr_busy) begin
                pop       = 1'b1;
                wr_data_d = head;
                state_d   = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            // The counter starts one cycle after wr_start, so the timeout lands BUSY_TMO cycles after it.
            WAIT_BUSY: if (wr_busy) state_d = WAIT_DONE;
                else if (cnt_q == CW'(BUSY_TMO - 2)) begin
                    tmo_err_d = 1'b1;
                    state_d   = IDLE;
                end else cnt_d = cnt_q + CW'(1);
            WAIT_DONE: if (!wr_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_start_d = state_d == LAUNCH;
        push       = s_valid && (!full || pop);
        drop       = s_valid && !push;
        overflow_d = overflow_q || drop;
`ifdef SFF_DROP_CNT_EN
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_data_q  <= '0;
            wr_start_q <= 1'b0;
            overflow_q <= 1'b0;
            tmo_err_q  <= 1'b0;
`ifdef SFF_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_data_q  <= wr_data_d;
            wr_start_q <= wr_start_d;
            overflow_q <= overflow_d;
            tmo_err_q  <= tmo_err_d;
`ifdef SFF_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign wr_start = wr_start_q;
    assign wr_data  = wr_data_q;
    assign overflow = overflow_q;
    assign tmo_err  = tmo_err_q;
`ifdef SFF_DROP_CNT_EN
    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_sample_fifo_feeder.sv
// tb_sample_fifo_feeder: scoreboard bench for sample_fifo_feeder with a simple SD writer model.
module tb_sample_fifo_feeder;
    localparam int BUSY_TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        wr_busy = 1'b0;
    logic        wr_start;
    logic [15:0] wr_data;
    logic        full, empty, overflow, tmo_err;
    logic [4:0]  level;
`ifdef SFF_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    sample_fifo_feeder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .wr_busy  (wr_busy),
        .wr_start (wr_start),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
`ifdef SFF_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .tmo_err  (tmo_err)
    );

    always #5 clk = ~clk;

    int          checks = 0, errs = 0;
    int          cyc = 0, last_start = -100, start_cnt = 0, busy_left = 0, hold = 34;
    bit          force_busy = 0, never_busy = 0, prev_tmo = 0;
    logic [15:0] q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Writer model: busy rises the cycle after wr_start and stays high for hold cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (force_busy) wr_busy = 1'b1;
        else if (busy_left > 0) begin
            wr_busy = 1'b1;
            busy_left--;
        end else wr_busy = 1'b0;
        if (wr_start && !never_busy) busy_left = hold;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (wr_start) begin
            if (last_start >= 0) chk("start_gap", 32'(cyc - last_start >= 4), 1);
            if (q.size() == 0) chk("unexp_start", 32'(wr_start), 0);
            else chk("wr_data", 32'(wr_data), 32'(q.pop_front()));
            last_start = cyc;
            start_cnt++;
        end
        if (tmo_err && !prev_tmo) chk("tmo_lat", cyc - last_start, BUSY_TMO);
        prev_tmo = tmo_err;
    end

    task automatic drive(input logic [15:0] d, input bit acc);
        s_valid = 1'b1;
        s_data  = d;
        if (acc) q.push_back(d);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        force_busy = 0;
        never_busy = 0;
        busy_left  = 0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int extra);
        int n = 0;
        while ((q.size() != 0 || wr_busy || !empty) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q", q.size(), 0);
        repeat (extra) @(negedge clk);
    endtask

    initial begin
        int s0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_wr_start", 32'(wr_start), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_tmo", 32'(tmo_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three words, level observed at 3 before the writer drains them.
        force_busy = 1;
        s0 = start_cnt;
        drive(16'h1111, 1);
        drive(16'h2222, 1);
        drive(16'h3333, 1);
        chk("t1_level3", 32'(level), 3);
        force_busy = 0;
        hold = 34;
        wait_idle(6);
        chk("t1_starts", start_cnt - s0, 3);
        chk("t1_level0", 32'(level), 0);

        // Overflow with writer held busy.
        force_busy = 1;
        for (int i = 0; i < 16; i++) drive(16'h5000 + 16'(i), 1);
        chk("t2_full", 32'(full), 1);
        chk("t2_level16", 32'(level), 16);
        chk("t2_ovf_before", 32'(overflow), 0);
        drive(16'h5FFF, 0);
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_level_still16", 32'(level), 16);
`ifdef SFF_DROP_CNT_EN
        chk("t2_drop_cnt", 32'(drop_cnt), 1);
`endif
        force_busy = 0;
        hold = 3;
        wait_idle(6);
        chk("t2_ovf_sticky", 32'(overflow), 1);

        // Push at full in the same cycle as an IDLE pop.
        do_reset();
        force_busy = 1;
        for (int i = 0; i < 16; i++) drive(16'h6000 + 16'(i), 1);
        chk("t3_full", 32'(full), 1);
        force_busy = 0;
        for (int n = 0; n < 10 && wr_busy; n++) @(negedge clk);
        chk("t3_busy_low", 32'(wr_busy), 0);
        drive(16'hABCD, 1);
        chk("t3_level16", 32'(level), 16);
        chk("t3_full_kept", 32'(full), 1);
        chk("t3_no_ovf", 32'(overflow), 0);
        wait_idle(6);
        chk("t3_no_ovf_end", 32'(overflow), 0);

        // Writer never answers: timeout, word lost, next word still launched.
        never_busy = 1;
        s0 = start_cnt;
        drive(16'h7001, 1);
        drive(16'h7002, 1);
        wait_idle(BUSY_TMO + 6);
        chk("t4_tmo", 32'(tmo_err), 1);
        chk("t4_starts", start_cnt - s0, 2);
        chk("t4_empty", 32'(empty), 1);

        // Reset while the writer is busy with five words queued behind it.
        do_reset();
        chk("t5_tmo_clr", 32'(tmo_err), 0);
        hold = 34;
        for (int i = 0; i < 6; i++) drive(16'h8000 + 16'(i), 1);
        for (int n = 0; n < 20 && !wr_busy; n++) @(negedge clk);
        chk("t5_busy", 32'(wr_busy), 1);
        @(negedge clk);
        chk("t5_level5", 32'(level), 5);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_empty", 32'(empty), 1);
        chk("t5_level0", 32'(level), 0);
        chk("t5_wr_start", 32'(wr_start), 0);
        s0 = start_cnt;
        repeat (40) @(negedge clk);
        chk("t5_no_pulses", start_cnt - s0, 0);
        busy_left = 0;
        hold = 1;
        drive(16'h8ABC, 1);
        wait_idle(6);
        chk("t5_resumed", start_cnt - s0, 1);

        // Forty words through continuous drain, wrapping the pointers.
        s0 = start_cnt;
        for (int i = 0; i < 40; i++) begin
            drive(16'h4000 + 16'(i), 1);
            repeat (2) @(negedge clk);
        end
        wait_idle(6);
        chk("t6_starts", start_cnt - s0, 40);
        chk("t6_no_ovf", 32'(overflow), 0);
        chk("t6_empty", 32'(empty), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
